// File: rtl/debounce_scheduler.sv
// Time-shared debouncer: one saturating-counter datapath sweeps all channels, one per clock, after each prescaler tick.
// Result for channel k is visible k+2 cycles after the tick. There is no backpressure; a tick that lands mid-sweep is dropped and flagged.
module debounce_scheduler #(
    parameter int N_CH       = 4,
    parameter int FACTOR_POW = 6,
    parameter int TICK_DIV   = 64
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [N_CH-1:0] in,
    output logic [N_CH-1:0] out,
    output logic [N_CH-1:0] press_o,
    output logic [N_CH-1:0] release_o,
    output logic            busy_o,
    output logic            overrun_o
);

    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int PR_W = $clog2(TICK_DIV);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);
    localparam logic [PR_W-1:0] PR_MAX  = PR_W'(TICK_DIV - 1);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t                state;
    logic [CH_W-1:0]       ch;
    logic [PR_W-1:0]       presc;
    logic                  tick;
    logic [N_CH-1:0]       s0;
    logic [N_CH-1:0]       s1;
    logic [FACTOR_POW-1:0] cnt [N_CH];
    logic [FACTOR_POW-1:0] cur_cnt;
    logic [FACTOR_POW-1:0] upd_cnt;
    logic                  new_lvl;

    // Two-flop synchroniser; the datapath only ever looks at s1.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s0 <= '0;
            s1 <= '0;
        end else begin
            s0 <= in;
            s1 <= s0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            presc <= '0;
        end else if (presc == PR_MAX) begin
            presc <= '0;
        end else begin
            presc <= presc + PR_W'(1);
        end
    end

    assign tick   = (presc == PR_MAX);
    assign busy_o = (state == SCAN);

    // Saturating step for the channel currently being serviced.
    always_comb begin
        cur_cnt = cnt[ch];
        upd_cnt = cur_cnt;
        if (s1[ch]) begin
            if (cur_cnt != '1) begin
                upd_cnt = cur_cnt + FACTOR_POW'(1);
            end
        end else if (cur_cnt != '0) begin
            upd_cnt = cur_cnt - FACTOR_POW'(1);
        end
        new_lvl = upd_cnt[FACTOR_POW-1];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            ch        <= '0;
            out       <= '0;
            press_o   <= '0;
            release_o <= '0;
            overrun_o <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            press_o   <= '0;
            release_o <= '0;
            case (state)
                IDLE: begin
                    if (tick) begin
                        state <= SCAN;
                        ch    <= '0;
                    end
                end
                SCAN: begin
                    cnt[ch]       <= upd_cnt;
                    out[ch]       <= new_lvl;
                    press_o[ch]   <= new_lvl & ~out[ch];
                    release_o[ch] <= ~new_lvl & out[ch];
                    // Sweeps are never queued; a late tick is lost for good.
                    if (tick) begin
                        overrun_o <= 1'b1;
                    end
                    if (ch == LAST_CH) begin
                        state <= IDLE;
                    end else begin
                        ch <= ch + CH_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_debounce_scheduler.sv
// Directed bench: sweep-level vector table on an 8-clock prescaler, plus a fast-tick instance for overrun and mid-sweep reset.
module tb_debounce_scheduler;

    logic       clk;
    logic       rst1, rst2;
    logic [3:0] in1, in2;
    logic [3:0] out1, press1, rel1;
    logic [3:0] out2, press2, rel2;
    logic       busy1, ovr1, busy2, ovr2;

    int n_chk;
    int n_pass;

    debounce_scheduler #(.N_CH(4), .FACTOR_POW(3), .TICK_DIV(8)) dut1 (
        .clk_i(clk), .rst_i(rst1), .in(in1), .out(out1), .press_o(press1),
        .release_o(rel1), .busy_o(busy1), .overrun_o(ovr1)
    );

    debounce_scheduler #(.N_CH(4), .FACTOR_POW(3), .TICK_DIV(4)) dut2 (
        .clk_i(clk), .rst_i(rst2), .in(in2), .out(out2), .press_o(press2),
        .release_o(rel2), .busy_o(busy2), .overrun_o(ovr2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0]  in_v;
        logic [3:0]  exp_out;
        logic [23:0] exp_p;
        logic [23:0] exp_r;
    } vec_t;

    vec_t tbl[27];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp_v);
        end else begin
            n_pass++;
        end
    endtask

    task automatic reset1();
        rst1 = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst1 = 1'b0;
    endtask

    // Applies v, waits for the next sweep, and records pulses for cycles T+1..T+6 (4 bits per cycle).
    task automatic do_sweep(input logic [3:0] v, output logic [23:0] pseq, output logic [23:0] rseq,
                            output logic [3:0] fout, output int bcnt, output bit seen);
        in1  = v;
        seen = 1'b0;
        pseq = '0;
        rseq = '0;
        bcnt = 0;
        fout = '0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (busy1) seen = 1'b1;
        end
        if (seen) begin
            for (int i = 0; i < 6; i++) begin
                if (i > 0) @(negedge clk);
                pseq[4*i +: 4] = press1;
                rseq[4*i +: 4] = rel1;
                if (busy1) bcnt++;
            end
            fout = out1;
        end
    endtask

    initial begin
        logic [23:0] pseq, rseq;
        logic [3:0]  fout;
        int          bcnt;
        int          cnt;
        bit          seen;

        n_chk  = 0;
        n_pass = 0;
        rst1   = 1'b1;
        rst2   = 1'b1;
        in1    = 4'b0000;
        in2    = 4'b1111;

        // in[0] rises after 4 sweeps; ch1 glitch; ch0 saturates; ch2 rises, saturates, falls, holds at 0, rises again.
        tbl[0]  = '{4'b0001, 4'b0000, 24'h0,      24'h0};
        tbl[1]  = '{4'b0001, 4'b0000, 24'h0,      24'h0};
        tbl[2]  = '{4'b0001, 4'b0000, 24'h0,      24'h0};
        tbl[3]  = '{4'b0001, 4'b0001, 24'h000010, 24'h0};
        tbl[4]  = '{4'b0011, 4'b0001, 24'h0,      24'h0};
        tbl[5]  = '{4'b0001, 4'b0001, 24'h0,      24'h0};
        tbl[6]  = '{4'b0001, 4'b0001, 24'h0,      24'h0};
        tbl[7]  = '{4'b0101, 4'b0001, 24'h0,      24'h0};
        tbl[8]  = '{4'b0101, 4'b0001, 24'h0,      24'h0};
        tbl[9]  = '{4'b0101, 4'b0001, 24'h0,      24'h0};
        tbl[10] = '{4'b0101, 4'b0101, 24'h004000, 24'h0};
        tbl[11] = '{4'b0101, 4'b0101, 24'h0,      24'h0};
        tbl[12] = '{4'b0101, 4'b0101, 24'h0,      24'h0};
        tbl[13] = '{4'b0101, 4'b0101, 24'h0,      24'h0};
        tbl[14] = '{4'b0101, 4'b0101, 24'h0,      24'h0};
        tbl[15] = '{4'b0001, 4'b0101, 24'h0,      24'h0};
        tbl[16] = '{4'b0001, 4'b0101, 24'h0,      24'h0};
        tbl[17] = '{4'b0001, 4'b0101, 24'h0,      24'h0};
        tbl[18] = '{4'b0001, 4'b0001, 24'h0,      24'h004000};
        tbl[19] = '{4'b0001, 4'b0001, 24'h0,      24'h0};
        tbl[20] = '{4'b0001, 4'b0001, 24'h0,      24'h0};
        tbl[21] = '{4'b0001, 4'b0001, 24'h0,      24'h0};
        tbl[22] = '{4'b0001, 4'b0001, 24'h0,      24'h0};
        tbl[23] = '{4'b0101, 4'b0001, 24'h0,      24'h0};
        tbl[24] = '{4'b0101, 4'b0001, 24'h0,      24'h0};
        tbl[25] = '{4'b0101, 4'b0001, 24'h0,      24'h0};
        tbl[26] = '{4'b0101, 4'b0101, 24'h004000, 24'h0};

        // Reset values, first-tick latency and sweep length.
        reset1();
        @(negedge clk);
        chk("rst out", 32'(out1), 32'h0);
        chk("rst press", 32'(press1), 32'h0);
        chk("rst release", 32'(rel1), 32'h0);
        chk("rst busy", 32'(busy1), 32'h0);
        chk("rst overrun", 32'(ovr1), 32'h0);
        cnt = 1;
        while (!busy1 && cnt < 30) begin
            @(negedge clk);
            cnt++;
        end
        chk("first busy cycle", 32'(cnt), 32'd9);
        cnt = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy1) cnt++;
            else break;
        end
        chk("busy length", 32'(cnt), 32'd4);

        // Sweep table.
        reset1();
        for (int i = 0; i < 27; i++) begin
            do_sweep(tbl[i].in_v, pseq, rseq, fout, bcnt, seen);
            chk($sformatf("sweep%0d seen", i), 32'(seen), 32'd1);
            chk($sformatf("sweep%0d busy", i), 32'(bcnt), 32'd4);
            chk($sformatf("sweep%0d out", i), 32'(fout), 32'(tbl[i].exp_out));
            chk($sformatf("sweep%0d press", i), 32'(pseq), 32'(tbl[i].exp_p));
            chk($sformatf("sweep%0d release", i), 32'(rseq), 32'(tbl[i].exp_r));
        end

        // All channels rise in the same sweep, on consecutive cycles.
        reset1();
        for (int s = 1; s <= 4; s++) begin
            do_sweep(4'b1111, pseq, rseq, fout, bcnt, seen);
            chk($sformatf("all%0d busy", s), 32'(bcnt), 32'd4);
            chk($sformatf("all%0d out", s), 32'(fout), (s == 4) ? 32'hF : 32'h0);
            chk($sformatf("all%0d press", s), 32'(pseq), (s == 4) ? 32'h084210 : 32'h0);
        end

        // Fast tick: overrun after the second tick, then reset while channel 2 is serviced.
        @(posedge clk);
        #1 rst2 = 1'b0;
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            cnt++;
            if (cnt == 8) chk("overrun before", 32'(ovr2), 32'h0);
            if (cnt == 9) chk("overrun after", 32'(ovr2), 32'h1);
        end
        chk("busy at ch2", 32'(busy2), 32'h1);
        rst2 = 1'b1;
        @(posedge clk);
        #1 rst2 = 1'b0;
        @(negedge clk);
        chk("midrst busy", 32'(busy2), 32'h0);
        chk("midrst overrun", 32'(ovr2), 32'h0);
        chk("midrst out", 32'(out2), 32'h0);
        chk("midrst press", 32'(press2), 32'h0);
        chk("midrst release", 32'(rel2), 32'h0);
        cnt = 1;
        while (press2 == 4'b0000 && cnt < 60) begin
            @(negedge clk);
            cnt++;
        end
        chk("post-reset press cycle", 32'(cnt), 32'd30);
        chk("post-reset press value", 32'(press2), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
